// File: rtl/instruction_fetch_if.sv
// Program-memory bus between the fetch stage and asynchronous-read instruction ROM.
// Master (fetch) drives the address; slave (memory) returns the word in the same cycle.
interface instruction_fetch_if #(
    parameter int ADDRESS_WIDTH      = 8,
    parameter int PROGRAM_DATA_WIDTH = 17
);
    logic [ADDRESS_WIDTH-1:0]      prog_addr;
    logic [PROGRAM_DATA_WIDTH-1:0] prog_data;

    modport master (
        output prog_addr,
        input  prog_data
    );

    modport slave (
        input  prog_addr,
        output prog_data
    );
endinterface

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, drives program memory and fills the IF/ID register.
// Priority per edge is reset, redirect (flush to bubble), stall (hold), then advance.
module instruction_fetch #(
    parameter int                          ADDRESS_WIDTH      = 8,
    parameter int                          PROGRAM_DATA_WIDTH = 17,
    parameter logic [ADDRESS_WIDTH-1:0]    RESET_PC           = '0,
    parameter logic [PROGRAM_DATA_WIDTH-1:0] NOP_INSTR        = '0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          stall,
    input  logic                          redirect_valid,
    input  logic [ADDRESS_WIDTH-1:0]      redirect_target,
    instruction_fetch_if.master           pmem,
    output logic [PROGRAM_DATA_WIDTH-1:0] ifid_instr,
    output logic [ADDRESS_WIDTH-1:0]      ifid_pc,
    output logic [ADDRESS_WIDTH-1:0]      ifid_pc_plus1,
    output logic                          ifid_valid,
    output logic [15:0]                   fetch_count
);

    typedef struct packed {
        logic [PROGRAM_DATA_WIDTH-1:0] instr;
        logic [ADDRESS_WIDTH-1:0]      pc;
        logic [ADDRESS_WIDTH-1:0]      pc_plus1;
        logic                          valid;
    } ifid_t;

    localparam logic [ADDRESS_WIDTH-1:0] PC_ONE    = ADDRESS_WIDTH'(1);
    localparam logic [15:0]              COUNT_MAX = 16'hFFFF;

    logic [ADDRESS_WIDTH-1:0] pc_q;
    logic [ADDRESS_WIDTH-1:0] pc_d;
    logic [ADDRESS_WIDTH-1:0] pc_inc;
    ifid_t                    ifid_q;
    ifid_t                    ifid_d;
    logic [15:0]              fetch_count_q;
    logic [15:0]              fetch_count_d;

    assign pc_inc = pc_q + PC_ONE;

    always_comb begin
        pc_d          = pc_q;
        ifid_d        = ifid_q;
        fetch_count_d = fetch_count_q;
        if (redirect_valid) begin
            // Wrong-path fetch becomes a bubble; pc fields keep their last value.
            pc_d         = redirect_target;
            ifid_d.instr = NOP_INSTR;
            ifid_d.valid = 1'b0;
        end else if (!stall) begin
            pc_d            = pc_inc;
            ifid_d.instr    = pmem.prog_data;
            ifid_d.pc       = pc_q;
            ifid_d.pc_plus1 = pc_inc;
            ifid_d.valid    = 1'b1;
            if (fetch_count_q != COUNT_MAX) begin
                fetch_count_d = fetch_count_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q            <= RESET_PC;
            ifid_q.instr    <= NOP_INSTR;
            ifid_q.pc       <= '0;
            ifid_q.pc_plus1 <= '0;
            ifid_q.valid    <= 1'b0;
            fetch_count_q   <= '0;
        end else begin
            pc_q          <= pc_d;
            ifid_q        <= ifid_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    assign pmem.prog_addr = pc_q;
    assign ifid_instr     = ifid_q.instr;
    assign ifid_pc        = ifid_q.pc;
    assign ifid_pc_plus1  = ifid_q.pc_plus1;
    assign ifid_valid     = ifid_q.valid;
    assign fetch_count    = fetch_count_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboard bench for instruction_fetch: a reference model queues the expected
// IF/ID image per edge; each entry is popped and compared one step after the edge.
module tb_instruction_fetch;

    typedef struct {
        logic [7:0]  addr;
        logic [16:0] instr;
        logic [7:0]  pc;
        logic [7:0]  pc1;
        logic        valid;
        logic [15:0] cnt;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        redirect_valid;
    logic [7:0]  redirect_target;
    logic [16:0] ifid_instr;
    logic [7:0]  ifid_pc;
    logic [7:0]  ifid_pc_plus1;
    logic        ifid_valid;
    logic [15:0] fetch_count;

    logic [16:0] mem [256];

    int n_chk  = 0;
    int n_pass = 0;

    exp_t sb [$];

    logic [7:0]  m_pc;
    logic [16:0] m_instr;
    logic [7:0]  m_ifpc;
    logic [7:0]  m_ifpc1;
    logic        m_valid;
    logic [15:0] m_cnt;

    instruction_fetch_if pm ();

    assign pm.prog_data = mem[pm.prog_addr];

    instruction_fetch dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .pmem            (pm),
        .ifid_instr      (ifid_instr),
        .ifid_pc         (ifid_pc),
        .ifid_pc_plus1   (ifid_pc_plus1),
        .ifid_valid      (ifid_valid),
        .fetch_count     (fetch_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp)
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else
            n_pass++;
    endtask

    // Drive one cycle of inputs, queue the model's post-edge image, compare it.
    task automatic step(input logic r, input logic s, input logic rv,
                        input logic [7:0] tgt);
        exp_t e;
        exp_t g;
        rst             = r;
        stall           = s;
        redirect_valid  = rv;
        redirect_target = tgt;
        if (r) begin
            m_pc = 8'h00; m_instr = 17'h0; m_ifpc = 8'h00;
            m_ifpc1 = 8'h00; m_valid = 1'b0; m_cnt = 16'h0;
        end else if (rv) begin
            m_pc = tgt; m_instr = 17'h0; m_valid = 1'b0;
        end else if (!s) begin
            m_instr = mem[m_pc];
            m_ifpc  = m_pc;
            m_ifpc1 = m_pc + 8'd1;
            m_valid = 1'b1;
            m_pc    = m_pc + 8'd1;
            if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        end
        e.addr = m_pc; e.instr = m_instr; e.pc = m_ifpc;
        e.pc1 = m_ifpc1; e.valid = m_valid; e.cnt = m_cnt;
        sb.push_back(e);
        @(posedge clk);
        #1;
        g = sb.pop_front();
        chk("prog_addr", 32'(pm.prog_addr), 32'(g.addr));
        chk("ifid_instr", 32'(ifid_instr), 32'(g.instr));
        chk("ifid_pc", 32'(ifid_pc), 32'(g.pc));
        chk("ifid_pc_plus1", 32'(ifid_pc_plus1), 32'(g.pc1));
        chk("ifid_valid", 32'(ifid_valid), 32'(g.valid));
        chk("fetch_count", 32'(fetch_count), 32'(g.cnt));
    endtask

    initial begin
        logic [16:0] prog [4];
        prog[0] = 17'h09200; prog[1] = 17'h0b400;
        prog[2] = 17'h0a088; prog[3] = 17'h05000;
        for (int i = 0; i < 256; i++) mem[i] = 17'(17'h10000 | (i * 7));
        for (int i = 0; i < 4; i++) mem[i] = prog[i];
        m_pc = '0; m_instr = '0; m_ifpc = '0; m_ifpc1 = '0;
        m_valid = 1'b0; m_cnt = '0;
        rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_target = '0;

        step(1, 0, 0, 8'h00);
        step(1, 0, 0, 8'h00);
        chk("rst_valid", 32'(ifid_valid), 32'd0);
        chk("rst_count", 32'(fetch_count), 32'd0);

        // Run to ifid_pc=1, then stall three cycles.
        for (int i = 0; i < 2; i++) begin
            step(0, 0, 0, 8'h00);
            chk("run_instr", 32'(ifid_instr), 32'(prog[i]));
            chk("run_pc1", 32'(ifid_pc_plus1), 32'(i + 1));
            chk("run_cnt", 32'(fetch_count), 32'(i + 1));
        end
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 0, 8'h00);
            chk("stall_addr", 32'(pm.prog_addr), 32'd2);
            chk("stall_instr", 32'(ifid_instr), 32'h0b400);
            chk("stall_cnt", 32'(fetch_count), 32'd2);
        end
        step(0, 0, 0, 8'h00);
        chk("post_stall", 32'(ifid_instr), 32'h0a088);
        step(0, 0, 0, 8'h00);
        chk("run_instr3", 32'(ifid_instr), 32'h05000);
        chk("run_cnt4", 32'(fetch_count), 32'd4);

        // Jump back to 0: one bubble, then instruction 0 again.
        step(0, 0, 1, 8'h00);
        chk("jmp_bubble", 32'(ifid_valid), 32'd0);
        chk("jmp_addr", 32'(pm.prog_addr), 32'd0);
        step(0, 0, 0, 8'h00);
        chk("jmp_instr", 32'(ifid_instr), 32'h09200);
        chk("jmp_pc", 32'(ifid_pc), 32'd0);

        step(0, 1, 1, 8'h10);
        chk("rs_addr", 32'(pm.prog_addr), 32'h10);
        chk("rs_bubble", 32'(ifid_valid), 32'd0);
        step(0, 0, 0, 8'h00);
        chk("rs_pc", 32'(ifid_pc), 32'h10);

        step(0, 0, 1, 8'hFF);
        step(0, 0, 0, 8'h00);
        chk("wrap_pc", 32'(ifid_pc), 32'hFF);
        chk("wrap_pc1", 32'(ifid_pc_plus1), 32'h00);
        chk("wrap_addr", 32'(pm.prog_addr), 32'h00);
        step(0, 0, 0, 8'h00);
        chk("wrap_pc0", 32'(ifid_pc), 32'h00);

        step(0, 1, 0, 8'h00);
        step(1, 1, 1, 8'h55);
        chk("mid_rst_addr", 32'(pm.prog_addr), 32'd0);
        chk("mid_rst_cnt", 32'(fetch_count), 32'd0);
        step(0, 0, 0, 8'h00);
        chk("after_rst", 32'(ifid_instr), 32'h09200);

        // Counter saturation: 1 so far, run up to FFFE, then past FFFF.
        rst = 1'b0; stall = 1'b0; redirect_valid = 1'b0;
        repeat (65533) @(posedge clk);
        #1;
        chk("cnt_fffe", 32'(fetch_count), 32'hFFFE);
        @(posedge clk); #1;
        chk("cnt_ffff", 32'(fetch_count), 32'hFFFF);
        repeat (3) @(posedge clk);
        #1;
        chk("cnt_sat", 32'(fetch_count), 32'hFFFF);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
